// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter
// Round-robin arbiter that shares one NUM_INPUTS:1 mux between NUM_INPUTS
// requesters. A grant is held until the holder strobes done_in, drops its
// request, or has held the mux for MAX_HOLD cycles (0 disables the limit).
// Every release is followed by one dead GAP cycle and one IDLE cycle, so two
// holders never overlap on the mux. All outputs are registered.

module mux_select_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req_in,
    input  logic                  done_in,
    output logic [NUM_INPUTS-1:0] grant_out,
    output logic [SEL_W-1:0]      select_out,
    output logic                  busy_out,
    output logic                  timeout_out
);

    // A zero-width counter is illegal, so a disabled limit keeps one bit.
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t                  state_q,   state_d;
    logic [NUM_INPUTS-1:0]   grant_q,   grant_d;
    logic [SEL_W-1:0]        sel_q,     sel_d;
    logic                    busy_q,    busy_d;
    logic                    timeout_q, timeout_d;
    logic [SEL_W-1:0]        ptr_q,     ptr_d;
    logic [HOLD_W-1:0]       hold_q,    hold_d;

    logic                    win_found;
    logic [SEL_W-1:0]        win_idx;
    logic [SEL_W-1:0]        search_idx;
    int unsigned             search_sum;

    logic                    rel_done;
    logic                    rel_drop;
    logic                    rel_limit;

    // Winner search: first requesting index starting at ptr, wrapping
    // modulo NUM_INPUTS (never produces an index >= NUM_INPUTS).
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        search_idx = '0;
        search_sum = 0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            search_sum = int'(ptr_q) + k;
            if (search_sum >= NUM_INPUTS) begin
                search_sum = search_sum - NUM_INPUTS;
            end
            search_idx = SEL_W'(search_sum);
            if (!win_found && req_in[search_idx]) begin
                win_found = 1'b1;
                win_idx   = search_idx;
            end
        end
    end

    // Release conditions for the current holder (sel_q is the holder index).
    always_comb begin
        rel_done  = done_in;
        rel_drop  = !req_in[sel_q];
        rel_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP sequence.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    sel_d            = win_idx;
                    busy_d           = 1'b1;
                    hold_d           = '0;
                    state_d          = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                    timeout_d = rel_limit && !rel_done && !rel_drop;
                    state_d   = GAP;
                end else if (hold_q != '1) begin
                    // Saturate so an unlimited grant cannot wrap the count.
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign grant_out   = grant_q;
    assign select_out  = sel_q;
    assign busy_out    = busy_q;
    assign timeout_out = timeout_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Testbench for mux_select_arbiter: two instances (4 inputs with a 4-cycle
// hold limit, 3 inputs with no limit) driven together. The driver updates a
// behavioural model at each falling edge and queues the expected outputs;
// the monitor pops and compares after each rising edge.

module tb_mux_select_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] req_a = '0;
    logic       done_a = 1'b0;
    logic [3:0] grant_a;
    logic [1:0] sel_a;
    logic       busy_a, to_a;

    logic [2:0] req_b = '0;
    logic       done_b = 1'b0;
    logic [2:0] grant_b;
    logic [1:0] sel_b;
    logic       busy_b, to_b;

    mux_select_arbiter #(.NUM_INPUTS(4), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_in(req_a), .done_in(done_a),
        .grant_out(grant_a), .select_out(sel_a), .busy_out(busy_a),
        .timeout_out(to_a)
    );

    mux_select_arbiter #(.NUM_INPUTS(3), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_in(req_b), .done_in(done_b),
        .grant_out(grant_b), .select_out(sel_b), .busy_out(busy_b),
        .timeout_out(to_b)
    );

    // Model: owner = current holder (-1 none), held = cycles the grant has
    // been visible, gap = the dead cycle after a release is showing.
    typedef struct {
        int owner;
        int held;
        int ptr;
        int sel;
        bit gap;
        bit to;
    } model_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   ea, eb;
    model_t m_a, m_b;
    int     checks = 0;
    int     failures = 0;

    function automatic model_t reset_model();
        model_t r;
        r.owner = -1; r.held = 0; r.ptr = 0; r.sel = 0; r.gap = 1'b0; r.to = 1'b0;
        return r;
    endfunction

    function automatic model_t step(model_t m, int n, int maxh, int req, bit done);
        model_t r = m;
        r.to = 1'b0;
        if (m.owner >= 0) begin
            bit a = done;
            bit b = ((req >> m.owner) & 1) == 0;
            bit c = (maxh != 0) && (m.held == maxh);
            if (a || b || c) begin
                r.owner = -1;
                r.ptr   = (m.owner + 1) % n;
                r.gap   = 1'b1;
                r.to    = c && !a && !b;
            end else begin
                r.held = m.held + 1;
            end
        end else if (m.gap) begin
            r.gap = 1'b0;
        end else if (req != 0) begin
            for (int k = 0; k < n; k++) begin
                int i = (m.ptr + k) % n;
                if (((req >> i) & 1) != 0) begin
                    r.owner = i; r.sel = i; r.held = 1;
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic exp_t expect_of(model_t m);
        exp_t e;
        e.grant = (m.owner >= 0) ? 4'(1 << m.owner) : 4'd0;
        e.sel   = 2'(m.sel);
        e.busy  = (m.owner >= 0);
        e.to    = m.to;
        return e;
    endfunction

    function automatic bit done_at(model_t m, int h);
        return (m.owner >= 0) && (m.held == h);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Called at a falling edge: apply inputs and queue the next-edge result.
    task automatic drive(input logic [3:0] ra, input bit da,
                         input logic [2:0] rb, input bit db);
        req_a = ra; done_a = da;
        req_b = rb; done_b = db;
        m_a = step(m_a, 4, 4, int'(ra), da);
        m_b = step(m_b, 3, 0, int'(rb), db);
        q_a.push_back(expect_of(m_a));
        q_b.push_back(expect_of(m_b));
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("rst_grant_a", int'(grant_a), 0);
            check("rst_sel_a",   int'(sel_a), 0);
            check("rst_busy_a",  int'(busy_a), 0);
            check("rst_to_a",    int'(to_a), 0);
            check("rst_grant_b", int'(grant_b), 0);
            check("rst_sel_b",   int'(sel_b), 0);
        end else if (q_a.size() == 0 || q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
        end else begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check("grant_a",   int'(grant_a), int'(ea.grant));
            check("sel_a",     int'(sel_a),   int'(ea.sel));
            check("busy_a",    int'(busy_a),  int'(ea.busy));
            check("timeout_a", int'(to_a),    int'(ea.to));
            check("grant_b",   int'(grant_b), int'(eb.grant[2:0]));
            check("sel_b",     int'(sel_b),   int'(eb.sel));
            check("busy_b",    int'(busy_b),  int'(eb.busy));
            check("timeout_b", int'(to_b),    int'(eb.to));
            check("sel_b_range", int'(sel_b < 2'd3), 1);
        end
    end

    logic [3:0] ra;
    logic [2:0] rb;

    initial begin
        m_a = reset_model();
        m_b = reset_model();
        req_a = 4'b1111;
        req_b = 3'b111;
        repeat (3) @(negedge clk);

        // Reset release with everyone requesting: requester 0 wins first.
        rst_n = 1'b1;
        drive(4'b1111, 1'b0, 3'b111, 1'b0);
        @(posedge clk);
        #2;
        check("first_grant_a", int'(grant_a), 1);
        check("first_sel_a",   int'(sel_a), 0);

        // Round-robin rotation with done in the first grant cycle.
        repeat (24) begin
            @(negedge clk);
            drive(4'b1111, done_at(m_a, 1), 3'b111, done_at(m_b, 2));
        end

        // Single requester, done three cycles into the grant.
        repeat (3) begin
            @(negedge clk);
            drive(4'b0000, 1'b0, 3'b000, 1'b0);
        end
        repeat (14) begin
            @(negedge clk);
            drive(4'b0100, done_at(m_a, 3), 3'b010, 1'b0);
        end

        // Hold limit on A; B holds far beyond any limit since it has none.
        repeat (16) begin
            @(negedge clk);
            drive(4'b1000, 1'b0, 3'b001, 1'b0);
        end

        // Withdrawal of the request mid-grant.
        repeat (10) begin
            @(negedge clk);
            drive((m_a.owner == 1 && m_a.held >= 2) ? 4'b0000 : 4'b0010, 1'b0,
                  3'b001, done_at(m_b, 3));
        end

        // done_in coinciding with the hold limit: no timeout pulse.
        repeat (14) begin
            @(negedge clk);
            drive(4'b0001, done_at(m_a, 4), 3'b111, done_at(m_b, 1));
        end

        // Randomized traffic with sticky request patterns.
        ra = 4'b0000;
        rb = 3'b000;
        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) ra = 4'($urandom);
            if ($urandom_range(3) == 0) rb = 3'($urandom);
            drive(ra, ($urandom_range(5) == 0), rb, ($urandom_range(5) == 0));
        end

        // Reset in the middle of a grant to requester 2 on B.
        for (int i = 0; i < 12 && m_b.owner != 2; i++) begin
            @(negedge clk);
            drive(4'b0000, 1'b0, 3'b100, 1'b0);
        end
        @(negedge clk);
        check("pre_rst_grant_b", int'(grant_b), 4);
        rst_n = 1'b0;
        #1;
        check("async_grant_b", int'(grant_b), 0);
        check("async_busy_b",  int'(busy_b), 0);
        check("async_sel_b",   int'(sel_b), 0);
        check("async_grant_a", int'(grant_a), 0);
        m_a = reset_model();
        m_b = reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 1'b0, 3'b111, 1'b0);
        repeat (14) begin
            @(negedge clk);
            drive(4'b0000, 1'b0, 3'b111, done_at(m_b, 1));
        end

        @(posedge clk);
        #2;
        check("sb_drained", q_a.size() + q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
Name: mux_select_arbiter

Overview:
Round-robin arbiter that shares one NUM_INPUTS:1 bit-select mux in the calculator datapath between NUM_INPUTS requesters. It grants one requester at a time and drives the mux select for as long as that requester holds the grant. A grant ends on explicit release, on request withdrawal, or on a hold-time limit. It sits between the operand/operation sequencing logic (requesters) and the mux select_in port.

Parameters:
NUM_INPUTS, 4, number of requesters and mux inputs; legal range >= 2, need not be a power of 2
MAX_HOLD, 16, maximum grant length in cycles; 0 disables the limit
SEL_W, $clog2(NUM_INPUTS), select width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_in  input  NUM_INPUTS  per-requester request level; bit i = requester i
done_in  input  1  release strobe from the current grant holder
grant_out  output  NUM_INPUTS  one-hot grant, all-zero when nothing is granted
select_out  output  SEL_W  drives mux select_in; index of current or last grantee
busy_out  output  1  high while any grant is active
timeout_out  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant_out=0, select_out=0, busy_out=0, timeout_out=0, priority pointer ptr=0, hold_cnt=0. Outputs take these values immediately, without waiting for a clock edge.
- All outputs are registered. There are no combinational paths from req_in or done_in to outputs.
- FSM states: IDLE, GRANT, GAP.
- IDLE: if req_in != 0, select the winner w = first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_INPUTS. On the next edge: grant_out=1<<w, select_out=w, busy_out=1, hold_cnt=0, state=GRANT. Request-to-grant latency is 1 cycle. If req_in == 0, stay in IDLE with all outputs held.
- GRANT: hold_cnt increments by 1 each cycle. The grant is released at the edge where any of these is true:
  a) done_in=1
  b) req_in[w]=0
  c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 (grant held exactly MAX_HOLD cycles)
- On release: grant_out=0, busy_out=0, ptr=(w+1) mod NUM_INPUTS, state=GAP. select_out keeps w.
- timeout_out=1 for the single cycle after a release caused only by condition c. If a or b coincides with c, there is no timeout pulse.
- GAP: one dead cycle with no grant; return to IDLE unconditionally. From release to the next grant is at least 2 cycles, so two holders never overlap on the mux.
- select_out changes only when a new grant is issued. It is stable for the whole grant and through GAP/IDLE.
- done_in is ignored in IDLE and GAP. Requests from non-granted bits have no effect during GRANT.
- Fairness: after requester i is served, it is lowest priority for the next arbitration. With all bits requesting continuously, grants rotate 0,1,...,N-1,0.
- Wrap-around: ptr and winner search are modulo NUM_INPUTS. When NUM_INPUTS is not a power of 2, select values >= NUM_INPUTS are never produced.
- hold_cnt is $clog2(MAX_HOLD+1) bits wide and never wraps in GRANT.
- Reset mid-grant: the grant is dropped immediately and the arbiter restarts at ptr=0.

Test Plan:
- Reset: hold rst_n=0 with req_in=4'b1111 -> grant_out=0, select_out=0, busy_out=0, timeout_out=0; release reset -> first clock after release gives grant_out=4'b0001, select_out=0.
- Single requester: req_in=4'b0100, done_in pulsed 3 cycles after grant -> grant_out=4'b0100, select_out=2 one cycle after request; grant drops on the done edge; one GAP cycle; regrant 2 cycles after release while the request is still held.
- Round-robin: req_in=4'b1111 held, done_in pulsed 1 cycle after each grant -> grant sequence 0,1,2,3,0, each separated by GAP, select_out tracking 2'd0..2'd3.
- Timeout: MAX_HOLD=4, req_in=4'b1000 held, done_in=0 -> grant held exactly 4 cycles; timeout_out=1 for one cycle; ptr wraps to 0; requester 3 regranted after GAP+IDLE.
- Withdrawal and coincidence: requester drops its req while granted -> release with no timeout. With MAX_HOLD=4, done_in asserted on the 4th grant cycle -> release with timeout_out=0.
- Reset mid-grant with NUM_INPUTS=3: grant to requester 2, then assert rst_n=0 asynchronously -> grant_out=0 at once; after reset with req_in=3'b111 -> grant to 0, then 1, then 2; select_out never reaches 3.
